// File: rtl/regfile32_pkg.sv
// Shared processor constants for the register file: widths, register
// count, write-counter width and the hardwired-zero register address.
package regfile32_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int WRCNT_W  = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile32_if.sv
// Register-file bus: two read ports, one write port, ALU flag capture and
// the accepted-write counter. The master is the pipeline, the slave the file.
interface regfile32_if #(
    parameter int DATA_W = regfile32_pkg::DATA_W,
    parameter int ADDR_W = regfile32_pkg::ADDR_W
);
    import regfile32_pkg::*;

    logic [ADDR_W-1:0]  rs_addr;
    logic [ADDR_W-1:0]  rt_addr;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic               we;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               flag_we;
    logic               iCarry;
    logic               iZero;
    logic               oCarry;
    logic               oZero;
    logic [WRCNT_W-1:0] oWrCount;

    modport master (
        output rs_addr, rt_addr, we, wr_addr, wr_data, flag_we, iCarry, iZero,
        input  rs_data, rt_data, oCarry, oZero, oWrCount
    );

    modport slave (
        input  rs_addr, rt_addr, we, wr_addr, wr_data, flag_we, iCarry, iZero,
        output rs_data, rt_data, oCarry, oZero, oWrCount
    );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: selects a register from the array, forces
// register 0 to zero and forwards the in-flight write when addresses match.
module regfile_rdport #(
    parameter int DATA_W = regfile32_pkg::DATA_W,
    parameter int ADDR_W = regfile32_pkg::ADDR_W
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  rd_addr,
    input  logic                               byp_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic [DATA_W-1:0]                  rd_data
);
    import regfile32_pkg::*;

    // Zero register wins, then the pending write, then stored contents.
    always_comb begin
        rd_data = regs[rd_addr];
        if (rd_addr == REG_ZERO) begin
            rd_data = '0;
        end else if (byp_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/regfile32.sv
// 32-entry register file with two bypassed read ports, one write port,
// registered ALU carry/zero flags and a wrapping accepted-write counter.
module regfile32 #(
    parameter int DATA_W = regfile32_pkg::DATA_W,
    parameter int ADDR_W = regfile32_pkg::ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    regfile32_if.slave  bus
);
    import regfile32_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [WRCNT_W-1:0]           wr_count;
    logic                         carry_q;
    logic                         zero_q;
    logic                         wr_accept;
    logic                         byp_en;

    // Writes to register 0 are dropped; reset also suppresses forwarding so
    // the read ports show the array while it is being cleared.
    assign wr_accept = bus.we && (bus.wr_addr != REG_ZERO);
    assign byp_en    = wr_accept && !rst;

    // Register array: cleared by reset, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (wr_accept) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Accepted-write counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_accept) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    // ALU status flags, captured independently of register writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (bus.flag_we) begin
            carry_q <= bus.iCarry;
            zero_q  <= bus.iZero;
        end
    end

    assign bus.oCarry   = carry_q;
    assign bus.oZero    = zero_q;
    assign bus.oWrCount = wr_count;

    regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport_rs (
        .regs    (regs),
        .rd_addr (bus.rs_addr),
        .byp_en  (byp_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_data (bus.rs_data)
    );

    regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport_rt (
        .regs    (regs),
        .rd_addr (bus.rt_addr),
        .byp_en  (byp_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_data (bus.rt_data)
    );

endmodule

// File: tb/tb_regfile32.sv
// Self-checking bench for regfile32: directed scenarios plus a randomized
// phase, all compared against an array-based reference model.
module tb_regfile32;
    import regfile32_pkg::*;

    logic clk = 1'b0;
    logic rst;

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    regfile32_if bus ();

    regfile32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [32];
    logic [15:0] expCount;
    logic        expCarry;
    logic        expZero;
    int          nTests = 0;
    int          nFail  = 0;

    task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] ra,
                                 input logic [4:0] rb, input logic fwe,
                                 input logic c, input logic z);
        rst         = r;
        bus.we      = w;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rs_addr = ra;
        bus.rt_addr = rb;
        bus.flag_we = fwe;
        bus.iCarry  = c;
        bus.iZero   = z;
        #1;
    endtask

    function automatic logic [31:0] refRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!rst && bus.we && bus.wr_addr == a) return bus.wr_data;
        return mem[a];
    endfunction

    task automatic stepClock();
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
            expCount = 16'd0;
            expCarry = 1'b0;
            expZero  = 1'b0;
        end else begin
            if (bus.we && bus.wr_addr != 5'd0) begin
                mem[bus.wr_addr] = bus.wr_data;
                expCount = expCount + 16'd1;
            end
            if (bus.flag_we) begin
                expCarry = bus.iCarry;
                expZero  = bus.iZero;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nTests++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_rs"},    bus.rs_data, refRead(bus.rs_addr));
        checkOutput({tag, "_rt"},    bus.rt_data, refRead(bus.rt_addr));
        checkOutput({tag, "_carry"}, {31'd0, bus.oCarry}, {31'd0, expCarry});
        checkOutput({tag, "_zero"},  {31'd0, bus.oZero},  {31'd0, expZero});
        checkOutput({tag, "_count"}, {16'd0, bus.oWrCount}, {16'd0, expCount});
    endtask

    initial begin
        logic [31:0] d;

        // Power-up reset held for two edges.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        stepClock();
        stepClock();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Every address reads zero on both ports after reset.
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 1'b0, 1'b0, 1'b0);
            checkOutput("rst_rs", bus.rs_data, 32'd0);
            checkOutput("rst_rt", bus.rt_data, 32'd0);
        end
        checkOutput("rst_carry", {31'd0, bus.oCarry}, 32'd0);
        checkOutput("rst_zero",  {31'd0, bus.oZero},  32'd0);
        checkOutput("rst_count", {16'd0, bus.oWrCount}, 32'd0);

        // Plain write to r5 then read back.
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("r5_read",  bus.rs_data, 32'hDEADBEEF);
        checkOutput("r5_count", {16'd0, bus.oWrCount}, 32'd1);

        // Write to r0 is neither forwarded nor stored nor counted.
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("r0_nobyp", bus.rs_data, 32'd0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("r0_read",  bus.rt_data, 32'd0);
        checkOutput("r0_count", {16'd0, bus.oWrCount}, 32'd1);

        // Same-cycle bypass on both ports at the same address.
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("byp_rs", bus.rs_data, 32'h12345678);
        checkOutput("byp_rt", bus.rt_data, 32'h12345678);
        stepClock();

        // Flags capture and hold.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            checkOutput("flag_hold_c", {31'd0, bus.oCarry}, 32'd1);
            checkOutput("flag_hold_z", {31'd0, bus.oZero},  32'd1);
            stepClock();
        end

        // Reset with a write and flag capture pending: reads show the array, write lost.
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hAAAA5555, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1);
        checkOutput("rstcyc_rs", bus.rs_data, 32'hDEADBEEF);
        checkOutput("rstcyc_rt", bus.rt_data, 32'd0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_r5", bus.rs_data, 32'd0);
        checkOutput("post_rst_r7", bus.rt_data, 32'd0);
        checkOutput("post_rst_c",  {31'd0, bus.oCarry}, 32'd0);
        checkOutput("post_rst_z",  {31'd0, bus.oZero},  32'd0);
        checkOutput("post_rst_n",  {16'd0, bus.oWrCount}, 32'd0);

        // First write after reset commits normally.
        applyStimulus(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("first_wr", bus.rs_data, 32'hCAFEF00D);
        checkOutput("first_n",  {16'd0, bus.oWrCount}, 32'd1);

        // Randomized traffic against the model, including rare resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom),
                          5'($urandom_range(0, 31)), $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                bus.rs_addr = bus.wr_addr;
                if ($urandom_range(0, 1) == 0) bus.rt_addr = bus.wr_addr;
                #1;
            end
            checkAll("rand");
            stepClock();
        end

        // Counter wrap: 65537 accepted writes to r1 from a clean reset.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        stepClock();
        d = 32'd0;
        for (int i = 1; i <= 65537; i++) begin
            d = $urandom;
            applyStimulus(1'b0, 1'b1, 5'd1, d, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
            stepClock();
            if (i == 65535) checkOutput("wrap_ffff", {16'd0, bus.oWrCount}, 32'h0000FFFF);
            if (i == 65536) checkOutput("wrap_zero", {16'd0, bus.oWrCount}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_one",  {16'd0, bus.oWrCount}, 32'd1);
        checkOutput("wrap_r1",   bus.rs_data, d);
        checkAll("wrap_final");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
